i_ref_sweep: RTL and testbench
==============================

I_REF_SWEEP -- requirements
Module: i_ref_sweep

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 10, the width of the current-reference code.
REQ-002 SHALL have parameter STEP, default 1, the code increment per sweep step (1 <= STEP <= 2**BUS_WIDTH-1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, the analog settle time per step in clocks (>= 1).
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1; high runs the sweep, low aborts it to IDLE.
REQ-007 SHALL have port unstable_in, input, 1, the raw asynchronous instability flag from the analog comparator.
REQ-008 SHALL have port i_ref, output, BUS_WIDTH, the registered current-reference code driven to the DAC and to i_ref_sampling.
REQ-009 SHALL have port ready, output, 1, a one-cycle strobe marking i_ref as settled and valid for sampling.
REQ-010 SHALL have port went_unstable, output, 1, a one-cycle pulse on each synchronized rising edge of unstable_in.
REQ-011 SHALL have port done, output, 1, a level flag that the sweep reached full scale.

Function
REQ-012 SHALL implement an FSM with states IDLE, SETTLE, STROBE and DONE, plus a settle counter of width ceil(log2(SETTLE_CYCLES+1)).
REQ-013 SHALL make the transition IDLE to SETTLE when enable=1: i_ref<=STEP, cnt<=SETTLE_CYCLES-1.
REQ-014 SHALL handle SETTLE per edge: if cnt>0, cnt decrements; if cnt==0, ready<=1 and state<=STROBE.
REQ-015 SHALL, in STROBE, set ready<=0; if i_ref > (2**BUS_WIDTH-1)-STEP, state<=DONE and done<=1; otherwise i_ref<=i_ref+STEP, cnt<=SETTLE_CYCLES-1, state<=SETTLE.
REQ-016 SHALL hold each i_ref code for exactly SETTLE_CYCLES+1 cycles, with ready high only in the last of them.
REQ-017 SHALL compare in BUS_WIDTH+1 bits so that i_ref never wraps and never exceeds 2**BUS_WIDTH-1.
REQ-018 SHALL, in DONE, hold i_ref and done=1 with no further ready strobes until enable goes low.
REQ-019 SHALL, when enable=0 in any state, go to IDLE at the next edge: ready<=0, done<=0, i_ref holds its last value.
REQ-020 SHALL synchronize unstable_in through two flops (s1, s2), keep the prior value s3, and detect a rising edge as s2 & ~s3.
REQ-021 SHALL, on a detected edge with enable=1, set went_unstable<=1 for one cycle in any non-IDLE state; otherwise went_unstable<=0.
REQ-022 SHALL, on a detected edge in SETTLE or STROBE, restart the sweep: i_ref<=STEP, cnt<=SETTLE_CYCLES-1, state<=SETTLE, ready<=0.
REQ-023 SHALL give the restart in REQ-022 priority over the REQ-014 and REQ-015 transitions in the same cycle, so no ready strobe is issued on that edge.
REQ-024 SHALL treat unstable_in held high as a single event: exactly one pulse and one restart per rising edge.
REQ-025 SHALL give enable=0 priority over a simultaneous unstable edge; in that case no went_unstable pulse is issued.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, i_ref=0, ready=0, went_unstable=0, done=0, cnt=0 and s1=s2=s3=0, regardless of clk.
REQ-027 SHALL, after rst deasserts, start the sweep only on the first rising edge with enable=1.

Verification
REQ-028 SHALL cover a basic sweep (BUS_WIDTH=4, STEP=1, SETTLE_CYCLES=3, enable held): i_ref=1..15, ready pulses every 4 cycles (15 in total), done=1 one cycle after the i_ref=15 strobe, then no further ready.
REQ-029 SHALL cover the step boundary: with STEP=4, codes 4, 8, 12 then DONE (12 > 11); with STEP=3, codes 3, 6, 9, 12, 15 then DONE; no code ever exceeds 15.
REQ-030 SHALL cover an unstable edge mid-sweep: unstable_in rises at i_ref=6 -> went_unstable high for one cycle after the third edge, i_ref returns to 1, and the next ready comes 4 cycles later.
REQ-031 SHALL cover unstable_in held high for 20 cycles -> exactly one went_unstable pulse and one restart.
REQ-032 SHALL cover an unstable edge coinciding with cnt==0 -> no ready on that edge and i_ref=1 next cycle.
REQ-033 SHALL cover enable dropped at i_ref=9 -> IDLE, ready=0, i_ref holds 9; re-enable -> i_ref=1. Separately, rst asserted mid-SETTLE -> all outputs 0 with no clock edge required.

Source files
------------

// File: rtl/i_ref_sweep.sv
// Current-reference sweep controller: steps the DAC code from STEP up to full scale,
// settling each code before a ready strobe, and restarts when the comparator reports instability.
module i_ref_sweep #(
  parameter int BUS_WIDTH     = 10,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 unstable_in,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 ready,
  output logic                 went_unstable,
  output logic                 done
);

  // state  | meaning
  // IDLE   | sweep stopped, i_ref holds last code
  // SETTLE | waiting for the analog side to settle on the current code
  // STROBE | ready is high for one cycle, next code chosen on exit
  // DONE   | full scale reached, holding until enable drops
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] STEP_CODE = BUS_WIDTH'(STEP);
  // One extra bit so the last-step test cannot wrap for large STEP.
  localparam logic [BUS_WIDTH:0]   LIMIT     = (BUS_WIDTH + 1)'((2 ** BUS_WIDTH) - 1 - STEP);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BUS_WIDTH-1:0] i_ref_nxt;
  logic                 ready_nxt, done_nxt, went_nxt;
  logic                 s1, s2, s3;
  logic                 rise;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      i_ref         <= '0;
      ready         <= 1'b0;
      done          <= 1'b0;
      went_unstable <= 1'b0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      i_ref         <= i_ref_nxt;
      ready         <= ready_nxt;
      done          <= done_nxt;
      went_unstable <= went_nxt;
      s1            <= unstable_in;
      s2            <= s1;
      s3            <= s2;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    i_ref_nxt = i_ref;
    ready_nxt = 1'b0;
    done_nxt  = done;
    went_nxt  = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end else begin
      if (rise && (state != IDLE)) went_nxt = 1'b1;
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          i_ref_nxt = STEP_CODE;
          cnt_nxt   = CNT_LOAD;
          done_nxt  = 1'b0;
        end
        SETTLE: begin
          if (rise) begin
            i_ref_nxt = STEP_CODE;
            cnt_nxt   = CNT_LOAD;
          end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            ready_nxt = 1'b1;
            state_nxt = STROBE;
          end
        end
        STROBE: begin
          if (rise) begin
            i_ref_nxt = STEP_CODE;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SETTLE;
          end else if ({1'b0, i_ref} > LIMIT) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            i_ref_nxt = i_ref + STEP_CODE;
            cnt_nxt   = CNT_LOAD;
            state_nxt = SETTLE;
          end
        end
        DONE: begin
          done_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_ref_sweep.sv
// Directed bench for i_ref_sweep: three instances (STEP 1/3/4, 4-bit code, 3-cycle settle)
// checked against hand-derived timing of 4 cycles per code.
module tb_i_ref_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, unstable_in = 1'b0;
  logic enable_b = 1'b0, unstable_b = 1'b0;
  logic [3:0] i_ref, i_ref3, i_ref4;
  logic ready, went_unstable, done;
  logic ready3, went3, done3, ready4, went4, done4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i_ref_sweep #(.BUS_WIDTH(4), .STEP(1), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .unstable_in(unstable_in),
    .i_ref(i_ref), .ready(ready), .went_unstable(went_unstable), .done(done));

  i_ref_sweep #(.BUS_WIDTH(4), .STEP(3), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable_b), .unstable_in(unstable_b),
    .i_ref(i_ref3), .ready(ready3), .went_unstable(went3), .done(done3));

  i_ref_sweep #(.BUS_WIDTH(4), .STEP(4), .SETTLE_CYCLES(3)) dut4 (
    .clk(clk), .rst(rst), .enable(enable_b), .unstable_in(unstable_b),
    .i_ref(i_ref4), .ready(ready4), .went_unstable(went4), .done(done4));

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary follows");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    enable_b = 1'b0;
    unstable_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (i_ref !== 4'd0 || ready !== 1'b0 || done !== 1'b0 || went_unstable !== 1'b0 ||
        i_ref3 !== 4'd0 || i_ref4 !== 4'd0) begin
      errors++;
      $display("FAIL reset: i_ref=%0d ready=%b done=%b went=%b i_ref3=%0d i_ref4=%0d, want all 0",
               i_ref, ready, done, went_unstable, i_ref3, i_ref4);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (i_ref !== 4'd0 || ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_no_enable: i_ref=%0d ready=%b done=%b, want 0 0 0", i_ref, ready, done);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (i_ref !== 4'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_enable: i_ref=%0d ready=%b, want 1 0", i_ref, ready);
    end
  endtask

  task automatic test_basic_sweep();
    int exp_code;
    logic exp_ready, exp_done;
    int pulses;
    pulses = 0;
    go_idle();
    enable = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      exp_code = (n - 1) / 4 + 1;
      if (exp_code > 15) exp_code = 15;
      exp_ready = (n % 4 == 0) && (n <= 60);
      exp_done = (n >= 61);
      if (ready === 1'b1) pulses++;
      checks++;
      if (i_ref !== 4'(exp_code) || ready !== exp_ready || done !== exp_done || went_unstable !== 1'b0) begin
        errors++;
        $display("FAIL basic_sweep n=%0d: i_ref=%0d ready=%b done=%b went=%b, want %0d %b %b 0",
                 n, i_ref, ready, done, went_unstable, exp_code, exp_ready, exp_done);
      end
    end
    checks++;
    if (pulses != 15) begin
      errors++;
      $display("FAIL basic_ready_count: got %0d, want 15", pulses);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || i_ref !== 4'd15 || ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_disable_after_done: done=%b i_ref=%0d ready=%b, want 0 15 0", done, i_ref, ready);
    end
  endtask

  task automatic test_step_boundary();
    int e3, e4, p3, p4;
    logic r3, r4, d3, d4;
    p3 = 0;
    p4 = 0;
    go_idle();
    enable_b = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      e4 = ((n - 1) / 4 + 1) * 4;
      if (e4 > 12) e4 = 12;
      r4 = (n % 4 == 0) && (n <= 12);
      d4 = (n >= 13);
      e3 = ((n - 1) / 4 + 1) * 3;
      if (e3 > 15) e3 = 15;
      r3 = (n % 4 == 0) && (n <= 20);
      d3 = (n >= 21);
      if (ready3 === 1'b1) p3++;
      if (ready4 === 1'b1) p4++;
      checks++;
      if (i_ref4 !== 4'(e4) || ready4 !== r4 || done4 !== d4 || went4 !== 1'b0) begin
        errors++;
        $display("FAIL step4 n=%0d: i_ref=%0d ready=%b done=%b, want %0d %b %b", n, i_ref4, ready4, done4, e4, r4, d4);
      end
      checks++;
      if (i_ref3 !== 4'(e3) || ready3 !== r3 || done3 !== d3 || went3 !== 1'b0) begin
        errors++;
        $display("FAIL step3 n=%0d: i_ref=%0d ready=%b done=%b, want %0d %b %b", n, i_ref3, ready3, done3, e3, r3, d3);
      end
    end
    checks++;
    if (p3 != 5 || p4 != 3) begin
      errors++;
      $display("FAIL step_ready_counts: step3=%0d step4=%0d, want 5 3", p3, p4);
    end
    enable_b = 1'b0;
  endtask

  task automatic test_unstable_mid();
    go_idle();
    enable = 1'b1;
    repeat (22) tick();
    checks++;
    if (i_ref !== 4'd6) begin
      errors++;
      $display("FAIL mid_pre: i_ref=%0d, want 6", i_ref);
    end
    unstable_in = 1'b1;
    tick();
    tick();
    checks++;
    if (went_unstable !== 1'b0 || ready !== 1'b1 || i_ref !== 4'd6) begin
      errors++;
      $display("FAIL mid_second_edge: went=%b ready=%b i_ref=%0d, want 0 1 6", went_unstable, ready, i_ref);
    end
    tick();
    checks++;
    if (went_unstable !== 1'b1 || ready !== 1'b0 || i_ref !== 4'd1) begin
      errors++;
      $display("FAIL mid_third_edge: went=%b ready=%b i_ref=%0d, want 1 0 1", went_unstable, ready, i_ref);
    end
    tick();
    tick();
    checks++;
    if (went_unstable !== 1'b0 || ready !== 1'b0 || i_ref !== 4'd1) begin
      errors++;
      $display("FAIL mid_settling: went=%b ready=%b i_ref=%0d, want 0 0 1", went_unstable, ready, i_ref);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || i_ref !== 4'd1) begin
      errors++;
      $display("FAIL mid_next_ready: ready=%b i_ref=%0d, want 1 1", ready, i_ref);
    end
    tick();
    checks++;
    if (ready !== 1'b0 || i_ref !== 4'd2) begin
      errors++;
      $display("FAIL mid_resume: ready=%b i_ref=%0d, want 0 2", ready, i_ref);
    end
    unstable_in = 1'b0;
  endtask

  task automatic test_unstable_at_cnt_zero();
    go_idle();
    enable = 1'b1;
    repeat (21) tick();
    unstable_in = 1'b1;
    tick();
    tick();
    checks++;
    if (i_ref !== 4'd6 || ready !== 1'b0) begin
      errors++;
      $display("FAIL cnt0_pre: i_ref=%0d ready=%b, want 6 0", i_ref, ready);
    end
    tick();
    checks++;
    if (went_unstable !== 1'b1 || ready !== 1'b0 || i_ref !== 4'd1) begin
      errors++;
      $display("FAIL cnt0_restart: went=%b ready=%b i_ref=%0d, want 1 0 1", went_unstable, ready, i_ref);
    end
    repeat (3) tick();
    checks++;
    if (ready !== 1'b1 || i_ref !== 4'd1 || went_unstable !== 1'b0) begin
      errors++;
      $display("FAIL cnt0_next_ready: ready=%b i_ref=%0d went=%b, want 1 1 0", ready, i_ref, went_unstable);
    end
    unstable_in = 1'b0;
  endtask

  task automatic test_unstable_held();
    int pulses;
    pulses = 0;
    go_idle();
    enable = 1'b1;
    for (int n = 1; n <= 47; n++) begin
      if (n == 6) unstable_in = 1'b1;
      if (n == 26) unstable_in = 1'b0;
      tick();
      if (went_unstable === 1'b1) pulses++;
      if (n == 8) begin
        checks++;
        if (i_ref !== 4'd1 || ready !== 1'b0 || went_unstable !== 1'b1) begin
          errors++;
          $display("FAIL held_restart: i_ref=%0d ready=%b went=%b, want 1 0 1", i_ref, ready, went_unstable);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_pulse_count: got %0d, want 1", pulses);
    end
    checks++;
    if (i_ref !== 4'd10 || ready !== 1'b1) begin
      errors++;
      $display("FAIL held_single_restart: i_ref=%0d ready=%b, want 10 1", i_ref, ready);
    end
  endtask

  task automatic test_enable_drop();
    go_idle();
    enable = 1'b1;
    repeat (34) tick();
    checks++;
    if (i_ref !== 4'd9) begin
      errors++;
      $display("FAIL drop_pre: i_ref=%0d, want 9", i_ref);
    end
    enable = 1'b0;
    tick();
    tick();
    checks++;
    if (i_ref !== 4'd9 || ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: i_ref=%0d ready=%b done=%b, want 9 0 0", i_ref, ready, done);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (i_ref !== 4'd1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_reenable: i_ref=%0d ready=%b, want 1 0", i_ref, ready);
    end
    go_idle();
    enable = 1'b1;
    repeat (5) tick();
    unstable_in = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (went_unstable !== 1'b0 || i_ref !== 4'd2 || ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_vs_unstable: went=%b i_ref=%0d ready=%b, want 0 2 0", went_unstable, i_ref, ready);
    end
    tick();
    checks++;
    if (went_unstable !== 1'b0) begin
      errors++;
      $display("FAIL drop_vs_unstable_late: went=%b, want 0", went_unstable);
    end
    unstable_in = 1'b0;
  endtask

  task automatic test_async_reset();
    go_idle();
    enable = 1'b1;
    repeat (6) tick();
    checks++;
    if (i_ref !== 4'd2) begin
      errors++;
      $display("FAIL areset_pre: i_ref=%0d, want 2", i_ref);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (i_ref !== 4'd0 || ready !== 1'b0 || done !== 1'b0 || went_unstable !== 1'b0) begin
      errors++;
      $display("FAIL areset_no_clock: i_ref=%0d ready=%b done=%b went=%b, want all 0",
               i_ref, ready, done, went_unstable);
    end
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (i_ref !== 4'd0) begin
      errors++;
      $display("FAIL areset_hold_idle: i_ref=%0d, want 0", i_ref);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (i_ref !== 4'd1) begin
      errors++;
      $display("FAIL areset_restart: i_ref=%0d, want 1", i_ref);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_step_boundary();
    test_unstable_mid();
    test_unstable_at_cnt_zero();
    test_unstable_held();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
